// File: rtl/tdm_xor_mask.sv
// tdm_xor_mask: strict round-robin TDM merge of CHANNELS inputs onto one output,
// each accepted word optionally XOR-masked with the low bits of a 16-bit LFSR.
module tdm_xor_mask #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mask_en,
  input  logic                      seed_load,
  input  logic [15:0]               seed_val,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [CW-1:0]    r_slot;
  logic [15:0]      r_lfsr;
  logic             w_acc;
  logic [WIDTH-1:0] w_data;
  logic [15:0]      w_lfsr_nxt;
  // The slot owner may only be offered the output when the register is free this cycle.
  assign in_ready   = (rst || (out_valid && !out_ready)) ? '0 : CHANNELS'(1) << r_slot;
  assign w_acc      = |(in_valid & in_ready);
  assign w_data     = in_data[r_slot*WIDTH +: WIDTH];
  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot    <= '0;
      r_lfsr    <= SEED;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else begin
      r_slot <= (r_slot == CW'(CHANNELS - 1)) ? '0 : r_slot + 1'b1;
      r_lfsr <= seed_load ? ((seed_val == '0) ? SEED : seed_val) : w_acc ? w_lfsr_nxt : r_lfsr;
      if (w_acc) begin
        out_data  <= mask_en ? w_data ^ r_lfsr[WIDTH-1:0] : w_data;
        out_chan  <= r_slot;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tdm_xor_mask.sv
// tb_tdm_xor_mask: directed and random stimulus against a queue scoreboard fed by a
// cycle-level reference model of the TDM slot, output occupancy and LFSR key stream.
module tb_tdm_xor_mask;
  localparam int W = 8;
  localparam int C = 4;
  localparam int CW = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [C*W-1:0] in_data = '0;
  logic [C-1:0] in_valid = '0;
  logic [C-1:0] in_ready;
  logic mask_en = 1'b0;
  logic seed_load = 1'b0;
  logic [15:0] seed_val = '0;
  logic [W-1:0] out_data;
  logic [CW-1:0] out_chan;
  logic out_valid;
  logic out_ready = 1'b0;
  int errs = 0;
  int checks = 0;
  logic [W+CW-1:0] q[$];
  int m_slot;
  logic m_valid;
  logic [15:0] m_lfsr;
  tdm_xor_mask #(.WIDTH(W), .CHANNELS(C), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mask_en(mask_en), .seed_load(seed_load), .seed_val(seed_val), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  task automatic model_reset();
    m_slot = 0;
    m_valid = 1'b0;
    m_lfsr = SEED;
    q.delete();
  endtask
  // Entered at posedge+2: drive one cycle of inputs, predict, then advance to next posedge+2.
  task automatic step(input logic [C-1:0] v, input logic [C*W-1:0] d, input logic m,
                      input logic ordy, input logic sl, input logic [15:0] sv);
    logic acc;
    logic [W-1:0] x;
    in_valid = v; in_data = d; mask_en = m; out_ready = ordy; seed_load = sl; seed_val = sv;
    #1;
    chk("in_ready", in_ready, (!m_valid || ordy) ? (1 << m_slot) : 0);
    chk("out_valid", out_valid, m_valid);
    acc = v[m_slot] && (!m_valid || ordy);
    if (acc) begin
      x = d[m_slot*W +: W];
      q.push_back({m ? x ^ m_lfsr[W-1:0] : x, CW'(m_slot)});
    end
    if (sl) m_lfsr = (sv == 0) ? SEED : sv;
    else if (acc) m_lfsr = lfsr_next(m_lfsr);
    m_valid = acc ? 1'b1 : (ordy ? 1'b0 : m_valid);
    m_slot = (m_slot + 1) % C;
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    step('0, '0, 1'b0, 1'b1, 1'b0, 16'h0);
  endtask
  task automatic to_slot(input int s);
    while (m_slot != s) idle();
  endtask
  task automatic expect_out(input string n, input logic [W-1:0] d, input logic [CW-1:0] c);
    chk(n, {out_valid, out_chan, out_data}, {1'b1, c, d});
  endtask
  // Monitor: pops one expected word per output handshake and watches stall stability.
  initial begin
    logic hold;
    logic [W+CW-1:0] held, e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) chk("stall_hold", {out_valid, out_data, out_chan}, {1'b1, held});
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("unexpected_output", {out_data, out_chan}, 'x);
          else begin
            e = q.pop_front();
            chk("scoreboard", {out_data, out_chan}, e);
          end
        end
        hold = out_valid && !out_ready;
        held = {out_data, out_chan};
      end
    end
  end
  initial begin
    logic [C*W-1:0] d;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", {out_valid, out_chan, out_data, in_ready}, '0);
    rst = 1'b0;
    model_reset();
    step(4'b0001, 32'h3C, 1'b1, 1'b1, 1'b0, 16'h0);
    expect_out("first_ch0", 8'hDD, 2'd0);
    repeat (3) step(4'b0001, 32'h3C, 1'b1, 1'b1, 1'b0, 16'h0);
    step(4'b0001, 32'h3C, 1'b1, 1'b1, 1'b0, 16'h0);
    expect_out("second_ch0", 8'hFF, 2'd0);
    repeat (3) idle();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, $urandom, 1'b1, 1'b1, 1'b0, 16'h0);
      expect_out("rr_chan", q[q.size()-1][CW +: W], 2'((i) % C));
    end
    repeat (5) step(4'b1111, $urandom, 1'b1, 1'b0, 1'b0, 16'h0);
    to_slot(0);
    step('0, '0, 1'b0, 1'b1, 1'b1, 16'h0);
    to_slot(2);
    step(4'b0100, 32'h003C_0000, 1'b1, 1'b1, 1'b0, 16'h0);
    expect_out("seed_zero", 8'hDD, 2'd2);
    to_slot(1);
    d = 32'h0000_5A00;
    step(4'b0010, d, 1'b1, 1'b1, 1'b1, 16'h1234);
    expect_out("load_old_key", 8'h5A ^ 8'hC3, 2'd1);
    step(4'b0100, '0, 1'b1, 1'b1, 1'b0, 16'h0);
    expect_out("load_new_key", 8'h34, 2'd2);
    step(4'b1000, 32'hA500_0000, 1'b0, 1'b1, 1'b0, 16'h0);
    expect_out("bypass", 8'hA5, 2'd3);
    step(4'b0001, '0, 1'b1, 1'b1, 1'b0, 16'h0);
    expect_out("bypass_advanced", 8'hD2, 2'd0);
    step(4'b0010, 32'h0000_7700, 1'b1, 1'b0, 1'b0, 16'h0);
    in_valid = '0;
    #1 rst = 1'b1;
    #1 chk("mid_reset", {out_valid, out_chan, out_data, in_ready}, '0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    step(4'b0001, 32'h3C, 1'b1, 1'b1, 1'b0, 16'h0);
    expect_out("post_reset", 8'hDD, 2'd0);
    for (int i = 0; i < 3000; i++) begin
      d = {$urandom};
      step(4'($urandom), d, 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
    end
    repeat (4) idle();
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
